// File: rtl/tff_down_counter_if.sv
// Control/status bundle for tff_down_counter: load/enable controls in, count and status out.
// master drives the controls; slave is the counter itself.
interface tff_down_counter_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output load, din, en, auto_reload,
    input  q, tc, busy, done
  );

  modport slave (
    input  load, din, en, auto_reload,
    output q, tc, busy, done
  );
endinterface

// File: rtl/tff_down_counter.sv
// Loadable down counter from per-bit toggle flops; one-shot or auto-reload with a registered tc pulse.
// Latency: load visible on q one edge later; no backpressure, en simply stalls the count.
module tff_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  tff_down_counter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [WIDTH-1:0] rl, rl_nxt;
  logic [WIDTH-1:0] t;
  logic             tc, tc_nxt;
  logic             run, step, term;

  assign run  = (state == RUN);
  assign step = run & bus.en & (q != '0);
  assign term = run & bus.en & (q == '0);

  // A bit toggles on a step when every lower bit is zero, i.e. it is about to borrow.
  assign t[0] = step;
  for (genvar i = 1; i < WIDTH; i++) begin : g_toggle
    assign t[i] = step & ~|q[i-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      q     <= '0;
      rl    <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      rl    <= rl_nxt;
      tc    <= tc_nxt;
    end
  end

  // Load outranks the terminal event, so a colliding terminal never pulses tc.
  always_comb begin
    state_nxt = state;
    q_nxt     = q ^ t;
    rl_nxt    = rl;
    tc_nxt    = 1'b0;
    if (bus.load) begin
      state_nxt = RUN;
      q_nxt     = bus.din;
      rl_nxt    = bus.din;
    end else if (term) begin
      tc_nxt = 1'b1;
      if (bus.auto_reload) begin
        q_nxt = rl;
      end else begin
        state_nxt = DONE;
      end
    end
  end

  assign bus.q    = q;
  assign bus.tc   = tc;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_tff_down_counter.sv
// Directed bench for tff_down_counter: driver queues expected q/tc/busy/done, monitor pops and compares.
module tb_tff_down_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  tff_down_counter_if #(.WIDTH(4)) bus ();

  tff_down_counter #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] q;
    logic       tc;
    logic       busy;
    logic       done;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event async_ev;

  task automatic compare_one();
    exp_t e;
    e = sb.pop_front();
    checks++;
    if (bus.q !== e.q || bus.tc !== e.tc || bus.busy !== e.busy || bus.done !== e.done) begin
      errors++;
      $display("FAIL %s: got q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
               e.tag, bus.q, bus.tc, bus.busy, bus.done, e.q, e.tc, e.busy, e.done);
    end
  endtask

  // Outputs are sampled 1 ns after each rising edge, or after an async-reset request.
  initial begin : monitor
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (sb.size() != 0) compare_one();
    end
  end

  task automatic push_exp(input logic [3:0] eq, input logic etc, input logic eb,
                          input logic ed, input string tag);
    exp_t e;
    e.q    = eq;
    e.tc   = etc;
    e.busy = eb;
    e.done = ed;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // One clock: drive inputs at the falling edge, expect the given outputs after the next rising edge.
  task automatic cyc(input logic ld, input logic [3:0] d, input logic e, input logic ar,
                     input logic [3:0] eq, input logic etc, input logic eb, input logic ed,
                     input string tag);
    @(negedge clk);
    bus.load        = ld;
    bus.din         = d;
    bus.en          = e;
    bus.auto_reload = ar;
    push_exp(eq, etc, eb, ed, tag);
    @(posedge clk);
  endtask

  task automatic async_check(input string tag);
    push_exp(4'd0, 1'b0, 1'b0, 1'b0, tag);
    ->async_ev;
    #2;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] v;
    bus.load        = 1'b0;
    bus.din         = 4'd0;
    bus.en          = 1'b0;
    bus.auto_reload = 1'b0;

    #1;
    async_check("reset_init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Async reset mid-count, then IDLE ignores en
    cyc(1'b1, 4'd6, 1'b0, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, "rst_load6");
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, "rst_cnt5");
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, "rst_cnt4");
    @(negedge clk);
    #2;
    rst = 1'b0;
    async_check("rst_async");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, "rst_idle_en");

    // One-shot from 3
    cyc(1'b1, 4'd3, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, "os_load3");
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, "os_q2");
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, "os_q1");
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, "os_q0");
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, "os_terminal");
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, "os_done_hold");

    // Auto-reload from 2
    cyc(1'b1, 4'd2, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, "ar_load2");
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, "ar_q1");
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, "ar_q0");
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, "ar_reload_a");
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, "ar_q1b");
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, "ar_q0b");
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, "ar_reload_b");

    // Enable gating from 5
    cyc(1'b1, 4'd5, 1'b0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, "eg_load5");
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, "eg_en1_a");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, "eg_en0_a");
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, "eg_en1_b");
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, "eg_en0_b");
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, "eg_en1_c");

    // Load colliding with a terminal event; then prove rl took 9
    cyc(1'b1, 4'd2, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, "col_load2");
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, "col_q1");
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, "col_q0");
    cyc(1'b1, 4'd9, 1'b1, 1'b1, 4'd9, 1'b0, 1'b1, 1'b0, "col_load9");
    for (int i = 8; i >= 0; i--) begin
      v = i[3:0];
      cyc(1'b0, 4'd0, 1'b1, 1'b1, v, 1'b0, 1'b1, 1'b0, "col_count");
    end
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0, "col_reload9");

    // Full range one-shot from 15
    cyc(1'b1, 4'd15, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0, "fr_load15");
    for (int i = 14; i >= 0; i--) begin
      v = i[3:0];
      cyc(1'b0, 4'd0, 1'b1, 1'b0, v, 1'b0, 1'b1, 1'b0, "fr_count");
    end
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, "fr_terminal");

    // rl=0 with auto-reload: tc held high, dropped only while en is low
    cyc(1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, "z_load0");
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, "z_tc_high");
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, "z_en0");
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, "z_en1");

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
